// File: rtl/code_lock_ctrl_if.sv
// Keypad-side bundle for the combination-lock controller:
// key strobes and programming request in, lock status out.
interface code_lock_ctrl_if;
  logic       key_valid;
  logic [3:0] key;
  logic       prog;
  logic       unlocked;
  logic       lockout;
  logic       err;
  logic       prog_done;
  logic [1:0] fail_cnt;

  modport master (
    output key_valid, key, prog,
    input  unlocked, lockout, err, prog_done, fail_cnt
  );

  modport slave (
    input  key_valid, key, prog,
    output unlocked, lockout, err, prog_done, fail_cnt
  );
endinterface

// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: serial digit check through one shared
// nibble comparator, failure lockout and in-place code reprogramming.
module comparator_4 (
  input  logic [3:0] i0,
  input  logic [3:0] i1,
  output logic       eq
);
  assign eq = (i0 == i1);
endmodule

module code_lock_ctrl #(
  parameter int                  DIGITS         = 4,
  parameter logic [4*DIGITS-1:0] RESET_CODE     = 16'h1234,
  parameter int                  MAX_FAIL       = 3,
  parameter int                  LOCK_CYCLES    = 1000,
  parameter int                  TIMEOUT_CYCLES = 5000,
  parameter int                  UNLOCK_CYCLES  = 500
) (
  input logic             clk,
  input logic             rst_n,
  code_lock_ctrl_if.slave bus
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TM1 = (LOCK_CYCLES > UNLOCK_CYCLES) ?
                       LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int TMAX = (TM1 > TIMEOUT_CYCLES) ? TM1 : TIMEOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int CW = 4 * DIGITS;

  localparam logic [IW-1:0] LAST  = IW'(DIGITS - 1);
  localparam logic [TW-1:0] TO_L  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNL_L = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LCK_L = TW'(LOCK_CYCLES - 1);
  localparam logic [2:0]    MAXF  = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE, CHECK, ENTRY, OPEN, PROG, LOCKED
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] code, code_n;
  logic [CW-1:0] shadow, shadow_n;
  logic [3:0]    key_reg, key_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] timer, timer_n;
  logic          mismatch, mis_n;
  logic [1:0]    fail, fail_n;
  logic          err_q, err_n;
  logic          done_q, done_n;
  logic          unl_q, lck_q;
  logic [3:0]    digit;
  logic          eq;
  logic [2:0]    fc_inc, fc_sat;

  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx == IW'(i)) digit = code[4*(DIGITS-1-i) +: 4];
  end

  comparator_4 u_cmp (
    .i0 (key_reg),
    .i1 (digit),
    .eq (eq)
  );

  // Saturating increment keeps the count from wrapping past MAX_FAIL
  assign fc_inc = {1'b0, fail} + 3'd1;
  assign fc_sat = (fc_inc > MAXF) ? MAXF : fc_inc;

  always_comb begin
    state_n  = state;
    code_n   = code;
    shadow_n = shadow;
    key_n    = key_reg;
    idx_n    = idx;
    timer_n  = timer;
    mis_n    = mismatch;
    fail_n   = fail;
    err_n    = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.key_valid) begin
          key_n   = bus.key;
          idx_n   = '0;
          mis_n   = 1'b0;
          state_n = CHECK;
        end
      end
      CHECK: begin
        mis_n   = mismatch | ~eq;
        timer_n = '0;
        if (idx < LAST) begin
          idx_n   = idx + 1'b1;
          state_n = ENTRY;
        end else if (!mis_n) begin
          fail_n  = '0;
          state_n = OPEN;
        end else begin
          err_n   = 1'b1;
          fail_n  = fc_sat[1:0];
          state_n = (fc_inc >= MAXF) ? LOCKED : IDLE;
        end
      end
      ENTRY: begin
        if (bus.key_valid) begin
          key_n   = bus.key;
          state_n = CHECK;
        end else if (timer >= TO_L) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      OPEN: begin
        if (bus.prog) begin
          idx_n   = '0;
          timer_n = '0;
          state_n = PROG;
        end else if (timer >= UNL_L) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      PROG: begin
        if (bus.key_valid) begin
          for (int i = 0; i < DIGITS; i++)
            if (idx == IW'(i)) shadow_n[4*(DIGITS-1-i) +: 4] = bus.key;
          timer_n = '0;
          if (idx >= LAST) begin
            code_n  = shadow_n;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else if (timer >= TO_L) begin
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      LOCKED: begin
        if (timer >= LCK_L) begin
          fail_n  = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= RESET_CODE;
      shadow   <= '0;
      key_reg  <= '0;
      idx      <= '0;
      timer    <= '0;
      mismatch <= 1'b0;
      fail     <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      unl_q    <= 1'b0;
      lck_q    <= 1'b0;
    end else begin
      state    <= state_n;
      code     <= code_n;
      shadow   <= shadow_n;
      key_reg  <= key_n;
      idx      <= idx_n;
      timer    <= timer_n;
      mismatch <= mis_n;
      fail     <= fail_n;
      err_q    <= err_n;
      done_q   <= done_n;
      unl_q    <= (state_n == OPEN);
      lck_q    <= (state_n == LOCKED);
    end
  end

  assign bus.unlocked  = unl_q;
  assign bus.lockout   = lck_q;
  assign bus.err       = err_q;
  assign bus.prog_done = done_q;
  assign bus.fail_cnt  = fail;
endmodule
